// File: rtl/fpu_div_pkg.sv
// Shared types and constants for the sequential mantissa divider.
// Optional feature macro: FPU_DIV_EARLY_TERM_EN (early exit on zero remainder).
package fpu_div_pkg;

  // Default mantissa width including the hidden bit.
  localparam int BIT_LENGTH_DEF = 24;

  // One quotient bit per step: integer bit, BIT_LENGTH-1 fraction bits, guard, one extra.
  localparam int DIV_ITER  = BIT_LENGTH_DEF + 2;
  localparam int Q_WIDTH   = BIT_LENGTH_DEF + 2;
  localparam int CNT_WIDTH = $clog2(DIV_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2
  } state_t;

endpackage

// File: rtl/fpu_div_step.sv
// One restoring-division iteration: compare, conditional subtract, shift left.
module fpu_div_step #(
  parameter int W = 24
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] divisor,
  output logic [W:0]   next_rem,
  output logic         q_bit
);

  logic [W:0] diff;

  assign diff = rem - {1'b0, divisor};

  // rem < 2*divisor keeps both candidates inside W bits before the shift.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    q_bit    = 1'b0;
    next_rem = {rem[W-1:0], 1'b0};
    if (rem >= {1'b0, divisor}) begin
      q_bit    = 1'b1;
      next_rem = {diff[W-1:0], 1'b0};
    end
  end

endmodule

// File: rtl/fpu_mantissa_divider.sv
// Sequential radix-2 restoring divider for normalized mantissas.
// Produces a normalized quotient plus exponent-adjust, guard and sticky bits.
// Optional feature macro: FPU_DIV_EARLY_TERM_EN -- leave CALC as soon as the
// remainder reaches zero; results are unchanged, latency becomes variable.
module fpu_mantissa_divider
  import fpu_div_pkg::*;
#(
  parameter int BIT_LENGTH = BIT_LENGTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIT_LENGTH-1:0] man_x,
  input  logic [BIT_LENGTH-1:0] man_y,
  output logic                  busy,
  output logic                  valid,
  output logic [BIT_LENGTH-1:0] result,
  output logic                  shift_div,
  output logic                  guard,
  output logic                  sticky,
  output logic                  div_zero
);

  state_t                state, state_next;
  logic [BIT_LENGTH:0]   rem;
  logic [BIT_LENGTH:0]   step_rem;
  logic [BIT_LENGTH-1:0] divisor;
  logic [Q_WIDTH-1:0]    q;
  logic [Q_WIDTH-1:0]    q_shift;
  logic [CNT_WIDTH-1:0]  count;
  logic                  dz_pending;
  logic                  step_q;
  logic                  early_done;

  fpu_div_step #(.W(BIT_LENGTH)) u_step (
    .rem      (rem),
    .divisor  (divisor),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  assign q_shift = {q[Q_WIDTH-2:0], step_q};
  assign busy    = (state != IDLE);

`ifdef FPU_DIV_EARLY_TERM_EN
  assign early_done = (step_rem == '0);
`else
  assign early_done = 1'b0;
`endif

  // State register.
  // NOTE: asynchronous reset sits in the sensitivity list so an abort takes effect without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: zero divisor skips iteration entirely.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (man_y == '0) ? NORM : CALC;
      CALC:    if ((count == '0) || early_done) state_next = NORM;
      NORM:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and output normalization.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem        <= '0;
      divisor    <= '0;
      q          <= '0;
      count      <= '0;
      dz_pending <= 1'b0;
      valid      <= 1'b0;
      result     <= '0;
      shift_div  <= 1'b0;
      guard      <= 1'b0;
      sticky     <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem        <= {1'b0, man_x};
            divisor    <= man_y;
            q          <= '0;
            count      <= CNT_WIDTH'(DIV_ITER - 1);
            dz_pending <= (man_y == '0);
          end
        end
        CALC: begin
          rem <= step_rem;
          if (count != '0) count <= count - 1'b1;
          // On early exit the untaken steps would all have shifted in zeros.
          if (early_done) q <= q_shift << count;
          else            q <= q_shift;
        end
        NORM: begin
          valid    <= 1'b1;
          div_zero <= dz_pending;
          if (dz_pending) begin
            result    <= '1;
            shift_div <= 1'b0;
            guard     <= 1'b0;
            sticky    <= 1'b0;
          end else if (q[Q_WIDTH-1]) begin
            result    <= q[Q_WIDTH-1 -: BIT_LENGTH];
            shift_div <= 1'b0;
            guard     <= q[1];
            sticky    <= q[0] | (rem != '0);
          end else begin
            result    <= q[Q_WIDTH-2 -: BIT_LENGTH];
            shift_div <= 1'b1;
            guard     <= q[0];
            sticky    <= (rem != '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mantissa_divider.sv
// Directed self-checking bench for fpu_mantissa_divider.
module tb_fpu_mantissa_divider;

  localparam int W = 24;

`ifdef FPU_DIV_EARLY_TERM_EN
  localparam int LAT_ONE = 2;
  localparam int LAT_FFF = 25;
  localparam int LAT_C0  = 3;
`else
  localparam int LAT_ONE = 27;
  localparam int LAT_FFF = 27;
  localparam int LAT_C0  = 27;
`endif
  localparam int LAT_TWO_THIRDS = 27;
  localparam int LAT_DZ         = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] man_x;
  logic [W-1:0] man_y;
  logic         busy;
  logic         valid;
  logic [W-1:0] result;
  logic         shift_div;
  logic         guard;
  logic         sticky;
  logic         div_zero;

  int checks      = 0;
  int errors      = 0;
  int valid_count = 0;

  fpu_mantissa_divider #(.BIT_LENGTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .man_x     (man_x),
    .man_y     (man_y),
    .busy      (busy),
    .valid     (valid),
    .result    (result),
    .shift_div (shift_div),
    .guard     (guard),
    .sticky    (sticky),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Count every valid pulse, sampled mid-cycle.
  always @(negedge clk) if (valid) valid_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; ends #1 after the accepting edge E0.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    man_x = x;
    man_y = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    man_x = ~x;
    man_y = ~y;
  endtask

  // Edges counted from the last sampled edge until valid is seen; 0 on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] res_e, input logic sd_e,
                               input logic g_e, input logic s_e, input logic dz_e);
    check({tag, " result"},    32'(result), 32'(res_e));
    check({tag, " shift_div"}, 32'(shift_div), 32'(sd_e));
    check({tag, " guard"},     32'(guard), 32'(g_e));
    check({tag, " sticky"},    32'(sticky), 32'(s_e));
    check({tag, " div_zero"},  32'(div_zero), 32'(dz_e));
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int lat_e, input logic [W-1:0] res_e, input logic sd_e,
                         input logic g_e, input logic s_e, input logic dz_e);
    int lat;
    int vc0;
    vc0 = valid_count;
    issue(x, y);
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    wait_valid(lat);
    check({tag, " latency"}, 32'(lat), 32'(lat_e));
    check_outputs(tag, res_e, sd_e, g_e, s_e, dz_e);
    check({tag, " busy_at_valid"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, " valid_drops"}, 32'(valid), 32'd0);
    check({tag, " result_held"}, 32'(result), 32'(res_e));
    check({tag, " one_valid"}, 32'(valid_count - vc0), 32'd1);
  endtask

  initial begin
    int lat;
    int vc0;

    rst   = 1'b1;
    start = 1'b0;
    man_x = '0;
    man_y = '0;

    // Reset state, during and after reset.
    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst valid", 32'(valid), 32'd0);
    check_outputs("rst", 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst busy", 32'(busy), 32'd0);
    check("post_rst valid", 32'(valid), 32'd0);
    check_outputs("post_rst", 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Main function, exact and inexact quotients.
    run_div("one_by_one", 24'h800000, 24'h800000, LAT_ONE, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_div("two_thirds", 24'h800000, 24'hC00000, LAT_TWO_THIRDS, 24'hAAAAAA, 1'b1, 1'b1, 1'b1, 1'b0);
    run_div("max_by_one", 24'hFFFFFF, 24'h800000, LAT_FFF, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_div("c0_by_80", 24'hC00000, 24'h800000, LAT_C0, 24'hC00000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Division by zero.
    run_div("div_zero", 24'hABCDEF, 24'h000000, LAT_DZ, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);

    // A start pulsed mid-operation is ignored.
    vc0 = valid_count;
    issue(24'h800000, 24'hC00000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    man_x = 24'h123456;
    man_y = 24'h000000;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_valid(lat);
    check("ignored latency", 32'(lat), 32'(LAT_TWO_THIRDS - 6));
    check_outputs("ignored", 24'hAAAAAA, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (35) @(posedge clk);
    #1;
    check("ignored valid_count", 32'(valid_count - vc0), 32'd1);
    check("ignored busy_idle", 32'(busy), 32'd0);

    // Reset mid-operation aborts with no valid.
    issue(24'hFFFFFF, 24'h800000);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort valid", 32'(valid), 32'd0);
    check_outputs("abort", 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
    vc0 = valid_count;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abort no_valid", 32'(valid_count - vc0), 32'd0);
    check("abort busy_idle", 32'(busy), 32'd0);

    // Recovery after abort.
    run_div("recover", 24'h800000, 24'hC00000, LAT_TWO_THIRDS, 24'hAAAAAA, 1'b1, 1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
